// File: rtl/md_unit_if.sv
// Request/response bundle between the E-stage controller and md_unit.
// Signal names follow the MIPS E-stage controller wiring.
interface md_unit_if;
    logic        start;
    logic [1:0]  md_op;
    logic        hi_we;
    logic        lo_we;
    logic        sel_hi;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] result;

    modport master (
        output start, md_op, hi_we, lo_we, sel_hi, A, B,
        input  busy, result
    );

    modport slave (
        input  start, md_op, hi_we, lo_we, sel_hi, A, B,
        output busy, result
    );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, fixed-latency
// mult/div with result committed when the countdown expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_unit_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_nxt_q, hi_nxt_d;
    logic [31:0] lo_nxt_q, lo_nxt_d;

    logic        is_signed;
    logic [63:0] op_a, op_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag, quot, rem;

    // One 64-bit multiplier serves both flavours via operand extension.
    always_comb begin
        is_signed = ~bus.md_op[0];
        op_a = {{32{is_signed & bus.A[31]}}, bus.A};
        op_b = {{32{is_signed & bus.B[31]}}, bus.B};
        prod = op_a * op_b;
    end

    // Divide on magnitudes, then restore C-style signs.
    always_comb begin
        a_neg  = is_signed & bus.A[31];
        b_neg  = is_signed & bus.B[31];
        a_mag  = a_neg ? -bus.A : bus.A;
        b_mag  = b_neg ? -bus.B : bus.B;
        b_safe = (bus.B == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_nxt_d = hi_nxt_q;
        lo_nxt_d = lo_nxt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = BUSY;
                    if (bus.md_op[1]) begin
                        cnt_d = 6'(DIV_CYCLES);
                        // Divide by zero commits the current HI/LO back.
                        if (bus.B == 32'd0) begin
                            hi_nxt_d = hi_q;
                            lo_nxt_d = lo_q;
                        end else begin
                            hi_nxt_d = rem;
                            lo_nxt_d = quot;
                        end
                    end else begin
                        cnt_d    = 6'(MULT_CYCLES);
                        hi_nxt_d = prod[63:32];
                        lo_nxt_d = prod[31:0];
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.A;
                    if (bus.lo_we) lo_d = bus.A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    hi_d    = hi_nxt_q;
                    lo_d    = lo_nxt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_nxt_q <= 32'd0;
            lo_nxt_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_nxt_q <= hi_nxt_d;
            lo_nxt_q <= lo_nxt_d;
        end
    end

    assign bus.busy   = (state_q == BUSY);
    assign bus.result = bus.sel_hi ? hi_q : lo_q;

endmodule
